sync_fifo: RTL and testbench

Single-clock, parametrised FIFO and successor to the dual-clock FIFO; for buffers whose producer and consumer share one clock, such as the measurement sample path and the command/response queues. Over the existing FIFO it adds arbitrary depth (power of two not required), a fill-level output, programmable almost-full/almost-empty thresholds, an optional first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.

---
 rtl/sync_fifo_pkg.sv | 26 ++
 rtl/sync_fifo_mem.sv | 39 +++
 rtl/sync_fifo.sv | 174 +++++++++++++++++
 tb/tb_sync_fifo.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared constants and width helpers for the single-clock FIFO.
//               Holds the read-mode encodings and the level/pointer width
//               calculations used by sync_fifo and its memory.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Read-mode selection for the FWFT parameter
    localparam int MODE_REG  = 0;
    localparam int MODE_FWFT = 1;

    // A level counter must represent 0..depth inclusive
    function automatic int calc_level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers index 0..depth-1; keep at least one bit
    function automatic int calc_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : Register-array simple dual-port storage for sync_fifo.
//               One synchronous write port, one asynchronous read port.
//               Contents are intentionally not reset.
// Ports       : clk                 - clock
//               i_wr_en / i_wr_ptr / i_wr_data - write port
//               i_rd_ptr / o_rd_data           - combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = calc_ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [PTR_WIDTH-1:0]  i_wr_ptr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [PTR_WIDTH-1:0]  i_rd_ptr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers never exceed DEPTH-1, so the index is always in range
    assign o_rd_data = r_mem[i_rd_ptr];

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO of arbitrary depth with fill level,
//               programmable almost-full/almost-empty thresholds, optional
//               first-word-fall-through read mode and sticky error flags.
// Ports       : clk, rst (sync, active-high)
//               data_in_vld/data_in       - write request and data
//               read_req                  - pop request
//               data_out_vld/data_out     - read data (0 when not valid)
//               fifo_full/fifo_empty      - level == DEPTH / level == 0
//               fill_level                - stored word count
//               almost_full/almost_empty  - threshold flags
//               overflow/underflow        - sticky error flags
//               clear_err                 - clears error flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int FIFO_DEPTH       = 8,
    parameter int FWFT             = MODE_REG,
    parameter int ALMOST_FULL_THR  = FIFO_DEPTH - 1,
    parameter int ALMOST_EMPTY_THR = 1,
    parameter int LEVEL_WIDTH      = calc_level_width(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data_in_vld,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic                   fifo_full,
    input  logic                   read_req,
    output logic                   data_out_vld,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   fifo_empty,
    output logic [LEVEL_WIDTH-1:0] fill_level,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clear_err
);

    localparam int                     c_PTR_WIDTH = calc_ptr_width(FIFO_DEPTH);
    localparam logic [c_PTR_WIDTH-1:0] c_PTR_LAST  = c_PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [LEVEL_WIDTH-1:0] c_LEVEL_MAX = LEVEL_WIDTH'(FIFO_DEPTH);
    localparam logic                   c_AF_RST    = (ALMOST_FULL_THR == 0);

    logic                   r_full;
    logic                   r_empty;
    logic                   r_afull;
    logic                   r_aempty;
    logic                   r_ovf;
    logic                   r_unf;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic [LEVEL_WIDTH-1:0] w_level_nxt;
    logic [c_PTR_WIDTH-1:0] r_wr_ptr;
    logic [c_PTR_WIDTH-1:0] r_rd_ptr;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic [DATA_WIDTH-1:0]  w_rd_data;

    // Explicit wrap so non-power-of-two depths work
    function automatic logic [c_PTR_WIDTH-1:0] f_ptr_inc(input logic [c_PTR_WIDTH-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Gating uses the current registered flags: a full FIFO rejects a write
    // even when a read is accepted in the same cycle, and vice versa.
    assign w_wr_en = data_in_vld & ~r_full;
    assign w_rd_en = read_req    & ~r_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_en && !w_rd_en) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_wr_en && w_rd_en) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // Flags are registered from the next level so they line up with
    // fill_level in every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= c_AF_RST;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_rd_en) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == c_LEVEL_MAX);
            r_empty  <= (w_level_nxt == '0);
            r_afull  <= (int'(w_level_nxt) >= ALMOST_FULL_THR);
            r_aempty <= (int'(w_level_nxt) <= ALMOST_EMPTY_THR);
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (data_in_vld && r_full) begin
                r_ovf <= 1'b1;
            end else if (clear_err) begin
                r_ovf <= 1'b0;
            end
            if (read_req && r_empty) begin
                r_unf <= 1'b1;
            end else if (clear_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .PTR_WIDTH  (c_PTR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word is shown directly; read_req only advances rd_ptr
            assign data_out_vld = ~r_empty;
            assign data_out     = r_empty ? '0 : w_rd_data;
        end else begin : g_reg
            logic                  r_dout_vld;
            logic [DATA_WIDTH-1:0] r_dout;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout_vld <= 1'b0;
                    r_dout     <= '0;
                end else begin
                    r_dout_vld <= w_rd_en;
                    r_dout     <= w_rd_en ? w_rd_data : '0;
                end
            end

            assign data_out_vld = r_dout_vld;
            assign data_out     = r_dout;
        end
    endgenerate

    assign fifo_full    = r_full;
    assign fifo_empty   = r_empty;
    assign fill_level   = r_level;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. Two instances of depth 5
//               share one stimulus stream: a registered-read instance with
//               thresholds 3/1 and a FWFT instance with default thresholds.
//               A queue-based reference model predicts level and flags;
//               scoreboards receive expected words and a monitor checks them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_DEPTH = 5;
    localparam int c_AF_A  = 3;
    localparam int c_AE_A  = 1;
    localparam int c_AF_B  = c_DEPTH - 1;
    localparam int c_AE_B  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_in_vld = 1'b0;
    logic [31:0] data_in = '0;
    logic        read_req = 1'b0;
    logic        clear_err = 1'b0;

    logic        full_a, empty_a, vld_a, afull_a, aempty_a, ovf_a, unf_a;
    logic [31:0] dout_a;
    logic [2:0]  level_a;
    logic        full_b, empty_b, vld_b, afull_b, aempty_b, ovf_b, unf_b;
    logic [31:0] dout_b;
    logic [2:0]  level_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stored contents plus expected sticky flags
    logic [31:0] q_model [$];
    logic [31:0] sb_a [$];   // words expected on the registered output
    logic [31:0] sb_b [$];   // words expected at the FWFT head, in order
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH       (32),
        .FIFO_DEPTH       (c_DEPTH),
        .FWFT             (0),
        .ALMOST_FULL_THR  (c_AF_A),
        .ALMOST_EMPTY_THR (c_AE_A)
    ) u_dut_reg (
        .clk          (clk),
        .rst          (rst),
        .data_in_vld  (data_in_vld),
        .data_in      (data_in),
        .fifo_full    (full_a),
        .read_req     (read_req),
        .data_out_vld (vld_a),
        .data_out     (dout_a),
        .fifo_empty   (empty_a),
        .fill_level   (level_a),
        .almost_full  (afull_a),
        .almost_empty (aempty_a),
        .overflow     (ovf_a),
        .underflow    (unf_a),
        .clear_err    (clear_err)
    );

    sync_fifo #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (c_DEPTH),
        .FWFT       (1)
    ) u_dut_fwft (
        .clk          (clk),
        .rst          (rst),
        .data_in_vld  (data_in_vld),
        .data_in      (data_in),
        .fifo_full    (full_b),
        .read_req     (read_req),
        .data_out_vld (vld_b),
        .data_out     (dout_b),
        .fifo_empty   (empty_b),
        .fill_level   (level_b),
        .almost_full  (afull_b),
        .almost_empty (aempty_b),
        .overflow     (ovf_b),
        .underflow    (unf_b),
        .clear_err    (clear_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both DUTs against the model after each edge
    task automatic check_state();
        int sz;
        sz = q_model.size();
        chk("level_a",  32'(level_a),  32'(sz));
        chk("full_a",   32'(full_a),   32'(sz == c_DEPTH));
        chk("empty_a",  32'(empty_a),  32'(sz == 0));
        chk("afull_a",  32'(afull_a),  32'(sz >= c_AF_A));
        chk("aempty_a", 32'(aempty_a), 32'(sz <= c_AE_A));
        chk("ovf_a",    32'(ovf_a),    32'(m_ovf));
        chk("unf_a",    32'(unf_a),    32'(m_unf));
        chk("level_b",  32'(level_b),  32'(sz));
        chk("full_b",   32'(full_b),   32'(sz == c_DEPTH));
        chk("empty_b",  32'(empty_b),  32'(sz == 0));
        chk("afull_b",  32'(afull_b),  32'(sz >= c_AF_B));
        chk("aempty_b", 32'(aempty_b), 32'(sz <= c_AE_B));
        chk("ovf_b",    32'(ovf_b),    32'(m_ovf));
        chk("unf_b",    32'(unf_b),    32'(m_unf));
        chk("vld_b",    32'(vld_b),    32'(sz > 0));
    endtask

    // One clock: drive inputs, advance the model, check after the edge
    task automatic cycle(input bit wr, input logic [31:0] d, input bit rd,
                         input bit clr, input bit rs);
        bit          was_full, was_empty;
        logic [31:0] v;
        rst         = rs;
        data_in_vld = wr;
        data_in     = d;
        read_req    = rd;
        clear_err   = clr;
        if (rs) begin
            q_model.delete();
            sb_b.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (q_model.size() == c_DEPTH);
            was_empty = (q_model.size() == 0);
            if (rd && !was_empty) begin
                v = q_model.pop_front();
                sb_a.push_back(v);
            end
            if (wr && !was_full) begin
                q_model.push_back(d);
                sb_b.push_back(d);
            end
            m_ovf = (wr && was_full)  ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_unf = (rd && was_empty) ? 1'b1 : (clr ? 1'b0 : m_unf);
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Monitor: output words checked mid-cycle against the scoreboards
    always @(negedge clk) begin
        if (vld_a) begin
            if (sb_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_a: got unexpected word 0x%0h, required none", dout_a);
            end else begin
                chk("data_a", dout_a, sb_a.pop_front());
            end
        end else begin
            chk("idle_zero_a", dout_a, 32'h0);
        end
        if (!rst) begin
            if (vld_b) begin
                if (sb_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_b: got unexpected word 0x%0h, required none", dout_b);
                end else if (read_req) begin
                    chk("data_b", dout_b, sb_b.pop_front());
                end else begin
                    chk("head_b", dout_b, sb_b[0]);
                end
            end else begin
                chk("idle_zero_b", dout_b, 32'h0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_wr;
        // Reset, then five idle cycles with clean error flags
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("rst_dout_a", dout_a, 32'h0);
        chk("rst_vld_a",  32'(vld_a), 32'h0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);

        // Fill with 0x11..0x55, then one rejected write
        for (int i = 1; i <= 5; i++) cycle(1, 32'(i * 'h11), 0, 0, 0);
        chk("full_after_5", 32'(full_a), 32'h1);
        cycle(1, 32'h66, 0, 0, 0);
        chk("overflow_set", 32'(ovf_a), 32'h1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
        chk("empty_after_drain", 32'(empty_a), 32'h1);
        cycle(0, 0, 0, 1, 0);

        // Wrap-around: 13 writes interleaved with reads, level kept 0..3
        n_wr = 0;
        while (n_wr < 13) begin
            bit w, r;
            w = (q_model.size() < 3) && ($urandom_range(0, 3) != 0);
            r = (q_model.size() > 0) && ($urandom_range(0, 2) != 0);
            if (!w && !r) w = (q_model.size() < 3);
            if (w) n_wr++;
            cycle(w, $urandom(), r, 0, 0);
        end
        while (q_model.size() > 0) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Simultaneous read+write at level 2, 0 and full
        cycle(1, 32'hA1, 0, 0, 0);
        cycle(1, 32'hA2, 0, 0, 0);
        cycle(1, 32'hA3, 1, 0, 0);
        chk("rw_level2", 32'(level_a), 32'd2);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 32'hB1, 1, 0, 0);
        chk("rw_level0", 32'(level_a), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1, 32'hC0 + 32'(i), 0, 0, 0);
        cycle(1, 32'hCF, 1, 0, 0);
        chk("rw_full", 32'(level_a), 32'(c_DEPTH - 1));
        while (q_model.size() > 0) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);

        // FWFT head visible one cycle after the write, no read_req needed
        cycle(1, 32'hA5, 0, 0, 0);
        chk("fwft_data", dout_b, 32'hA5);
        chk("fwft_vld",  32'(vld_b), 32'h1);
        cycle(0, 0, 1, 0, 0);
        chk("fwft_empty", 32'(empty_b), 32'h1);

        // Underflow: set, clear colliding with a new set, then clear
        cycle(0, 0, 1, 0, 0);
        chk("unf_set", 32'(unf_a), 32'h1);
        cycle(0, 0, 1, 1, 0);
        chk("unf_set_wins", 32'(unf_a), 32'h1);
        cycle(0, 0, 0, 1, 0);
        chk("unf_cleared", 32'(unf_a), 32'h0);

        // Mid-operation reset discards contents
        for (int i = 0; i < 3; i++) cycle(1, $urandom(), 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("midrst_level", 32'(level_a), 32'h0);

        // Randomised traffic with occasional clears and resets
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 55, $urandom(), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
        end

        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        chk("sb_a_drained", 32'(sb_a.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
